mux_n_scan: RTL and testbench

Parametrised N-channel, W-bit registered multiplexer. It is the successor to the 2:1 single-bit combinational mux. It adds registered output, an enable and out-of-range detection. It also adds an auto-scan mode that rotates through the channels on a programmable dwell count. It sits between multi-channel sources (switches, sensor lanes, test patterns) and a single downstream consumer such as an LED/segment driver or a UART/debug port.

---
 rtl/mux_n_scan.sv | 81 ++++++++
 tb/tb_mux_n_scan.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_n_scan.sv
`default_nettype none
// ============================================================================
// mux_n_scan : N-channel registered mux with manual select and timed auto-scan
// Revision   : 1.0
// ============================================================================
module mux_n_scan #(
  parameter int WIDTH = 1,
  parameter int CH    = 4,
  parameter int SEL_W = 2,
  parameter int DWELL = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CH*WIDTH-1:0]   din,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  en,
  output logic [WIDTH-1:0]      dout,
  output logic [SEL_W-1:0]      ch_out,
  output logic                  out_valid,
  output logic                  wrap
);

  localparam int               CNT_W      = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W:0]   C_CH       = (SEL_W+1)'(CH);
  localparam logic [SEL_W-1:0] C_LAST_CH  = SEL_W'(CH - 1);
  localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(DWELL - 1);

  logic [SEL_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_sel_data;
  logic [WIDTH-1:0] w_ptr_data;
  logic             w_sel_ok;

  // Compare-based selection keeps out-of-range indices from reaching din.
  always_comb begin
    w_sel_data = '0;
    w_ptr_data = '0;
    for (int k = 0; k < CH; k++) begin
      if ({1'b0, sel} == k[SEL_W:0])   w_sel_data = din[k*WIDTH +: WIDTH];
      if ({1'b0, r_ptr} == k[SEL_W:0]) w_ptr_data = din[k*WIDTH +: WIDTH];
    end
  end

  assign w_sel_ok = ({1'b0, sel} < C_CH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout      <= '0;
      ch_out    <= '0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
      r_ptr     <= '0;
      r_cnt     <= '0;
    end else if (!en) begin
      wrap <= 1'b0;
    end else if (!mode) begin
      // Holding ptr/cnt at zero makes every scan entry start fresh on ch 0.
      ch_out    <= sel;
      r_ptr     <= '0;
      r_cnt     <= '0;
      wrap      <= 1'b0;
      dout      <= w_sel_ok ? w_sel_data : '0;
      out_valid <= w_sel_ok;
    end else begin
      dout      <= w_ptr_data;
      ch_out    <= r_ptr;
      out_valid <= 1'b1;
      if (r_cnt == C_LAST_CNT) begin
        r_cnt <= '0;
        r_ptr <= (r_ptr == C_LAST_CH) ? '0 : r_ptr + SEL_W'(1);
        wrap  <= (r_ptr == C_LAST_CH);
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
        wrap  <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_n_scan.sv
`default_nettype none
// Bench for mux_n_scan: a 4-channel/DWELL=3 unit and a 3-channel/DWELL=2 unit
// share stimulus and are checked against a position-counting reference model.
module tb_mux_n_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] din;
  logic        mode;
  logic [1:0]  sel;
  logic        en;

  logic [7:0]  dout_a, dout_b;
  logic [1:0]  ch_a, ch_b;
  logic        vld_a, vld_b, wrap_a, wrap_b;

  int checks = 0;
  int errors = 0;

  // Reference state: expected outputs plus the number of enabled scan edges
  // since scan was entered (the scan position is derived from it arithmetically).
  int unsigned sn [2];
  logic [7:0]  e_dout [2];
  logic [1:0]  e_ch [2];
  logic        e_vld [2];
  logic        e_wrap [2];

  always #5 clk = ~clk;

  mux_n_scan #(.WIDTH(8), .CH(4), .SEL_W(2), .DWELL(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .din(din), .mode(mode), .sel(sel), .en(en),
    .dout(dout_a), .ch_out(ch_a), .out_valid(vld_a), .wrap(wrap_a)
  );

  mux_n_scan #(.WIDTH(8), .CH(3), .SEL_W(2), .DWELL(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(din[23:0]), .mode(mode), .sel(sel), .en(en),
    .dout(dout_b), .ch_out(ch_b), .out_valid(vld_b), .wrap(wrap_b)
  );

  // One clock edge; the model consumes the inputs present at that edge.
  task automatic tick();
    @(posedge clk);
    for (int u = 0; u < 2; u++) begin
      int c;
      int d;
      int k;
      c = (u == 0) ? 4 : 3;
      d = (u == 0) ? 3 : 2;
      if (!rst_n) begin
        e_dout[u] = 8'h00; e_ch[u] = 2'd0; e_vld[u] = 1'b0; e_wrap[u] = 1'b0; sn[u] = 0;
      end else if (!en) begin
        e_wrap[u] = 1'b0;
      end else if (!mode) begin
        sn[u]     = 0;
        e_ch[u]   = sel;
        e_wrap[u] = 1'b0;
        if (int'(sel) < c) begin
          e_dout[u] = din[int'(sel)*8 +: 8];
          e_vld[u]  = 1'b1;
        end else begin
          e_dout[u] = 8'h00;
          e_vld[u]  = 1'b0;
        end
      end else begin
        k         = int'((sn[u] / d) % c);
        e_dout[u] = din[k*8 +: 8];
        e_ch[u]   = k[1:0];
        e_vld[u]  = 1'b1;
        e_wrap[u] = ((sn[u] % (c*d)) == (c*d - 1));
        sn[u]++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; mode = 1'b0; sel = 2'd0; din = 32'hDDCCBBAA;
    repeat (3) tick();
    checks++;
    if ({dout_a, ch_a, vld_a, wrap_a} !== 12'h000) begin
      errors++;
      $display("FAIL reset_a: got dout=%h ch=%0d vld=%b wrap=%b, want all zero", dout_a, ch_a, vld_a, wrap_a);
    end
    checks++;
    if ({dout_b, ch_b, vld_b, wrap_b} !== 12'h000) begin
      errors++;
      $display("FAIL reset_b: got dout=%h ch=%0d vld=%b wrap=%b, want all zero", dout_b, ch_b, vld_b, wrap_b);
    end
  endtask

  task automatic test_manual_sweep();
    logic [7:0] want [4];
    want[0] = 8'hAA; want[1] = 8'hBB; want[2] = 8'hCC; want[3] = 8'hDD;
    rst_n = 1'b1; en = 1'b1; mode = 1'b0; din = 32'hDDCCBBAA;
    for (int s = 0; s < 4; s++) begin
      sel = s[1:0];
      for (int i = 0; i < 20; i++) begin
        tick();
        checks++;
        if ({dout_a, ch_a, vld_a} !== {want[s], s[1:0], 1'b1} || wrap_a !== 1'b0) begin
          errors++;
          $display("FAIL manual_a sel=%0d cyc=%0d: got dout=%h ch=%0d vld=%b wrap=%b, want dout=%h vld=1",
                   s, i, dout_a, ch_a, vld_a, wrap_a, want[s]);
        end
        checks++;
        if ({dout_b, ch_b, vld_b, wrap_b} !== {e_dout[1], e_ch[1], e_vld[1], e_wrap[1]}) begin
          errors++;
          $display("FAIL manual_b sel=%0d cyc=%0d: got %h/%0d/%b/%b, want %h/%0d/%b/%b", s, i,
                   dout_b, ch_b, vld_b, wrap_b, e_dout[1], e_ch[1], e_vld[1], e_wrap[1]);
        end
      end
    end
  endtask

  task automatic test_out_of_range();
    rst_n = 1'b1; en = 1'b1; mode = 1'b0; din = 32'hDDCCBBAA; sel = 2'd3;
    tick();
    checks++;
    if ({dout_b, ch_b, vld_b} !== {8'h00, 2'd3, 1'b0}) begin
      errors++;
      $display("FAIL oor_b: got dout=%h ch=%0d vld=%b, want dout=00 ch=3 vld=0", dout_b, ch_b, vld_b);
    end
    sel = 2'd1;
    tick();
    checks++;
    if ({dout_b, ch_b, vld_b} !== {8'hBB, 2'd1, 1'b1}) begin
      errors++;
      $display("FAIL oor_restore_b: got dout=%h ch=%0d vld=%b, want dout=BB ch=1 vld=1", dout_b, ch_b, vld_b);
    end
  endtask

  task automatic test_scan_rotation();
    logic [1:0] seq [13];
    for (int i = 0; i < 12; i++) seq[i] = 2'(i / 3);
    seq[12] = 2'd0;
    rst_n = 1'b1; en = 1'b1; mode = 1'b0; sel = 2'd2;
    tick();
    mode = 1'b1;
    for (int i = 0; i < 13; i++) begin
      din = $urandom;
      sel = 2'($urandom);
      tick();
      checks++;
      if (ch_a !== seq[i] || wrap_a !== (i == 11) || vld_a !== 1'b1 || dout_a !== e_dout[0]) begin
        errors++;
        $display("FAIL scan_rot out=%0d: got ch=%0d wrap=%b vld=%b dout=%h, want ch=%0d wrap=%b vld=1 dout=%h",
                 i+1, ch_a, wrap_a, vld_a, dout_a, seq[i], (i == 11), e_dout[0]);
      end
    end
  endtask

  task automatic test_stall_mode_switch();
    logic [7:0] frozen;
    rst_n = 1'b1; en = 1'b1; mode = 1'b0; sel = 2'd0;
    tick();
    mode = 1'b1;
    for (int i = 0; i < 5; i++) begin din = $urandom; tick(); end
    checks++;
    if (ch_a !== 2'd1) begin
      errors++;
      $display("FAIL stall_pre: got ch=%0d, want 1", ch_a);
    end
    frozen = dout_a;
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      din = $urandom;
      tick();
      checks++;
      if (dout_a !== frozen || ch_a !== 2'd1 || wrap_a !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold %0d: got dout=%h ch=%0d wrap=%b, want dout=%h ch=1 wrap=0",
                 i, dout_a, ch_a, wrap_a, frozen);
      end
    end
    en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      din = $urandom;
      tick();
      checks++;
      if (ch_a !== 2'(1 + i) || dout_a !== e_dout[0]) begin
        errors++;
        $display("FAIL stall_resume %0d: got ch=%0d dout=%h, want ch=%0d dout=%h", i, ch_a, dout_a, 1 + i, e_dout[0]);
      end
    end
    mode = 1'b0; sel = 2'd3; din = 32'h44332211;
    tick();
    checks++;
    if (dout_a !== 8'h44 || ch_a !== 2'd3 || vld_a !== 1'b1) begin
      errors++;
      $display("FAIL to_manual: got dout=%h ch=%0d vld=%b, want dout=44 ch=3 vld=1", dout_a, ch_a, vld_a);
    end
    mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = $urandom;
      tick();
      checks++;
      if (ch_a !== ((i < 3) ? 2'd0 : 2'd1) || dout_a !== e_dout[0]) begin
        errors++;
        $display("FAIL rescan %0d: got ch=%0d dout=%h, want ch=%0d dout=%h", i, ch_a, dout_a, (i < 3) ? 0 : 1, e_dout[0]);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    rst_n = 1'b1; en = 1'b1; mode = 1'b0;
    tick();
    mode = 1'b1;
    for (int i = 0; i < 7; i++) begin din = $urandom; tick(); end
    checks++;
    if (ch_a !== 2'd2) begin
      errors++;
      $display("FAIL midscan_pre: got ch=%0d, want 2", ch_a);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({dout_a, ch_a, vld_a, wrap_a} !== 12'h000) begin
      errors++;
      $display("FAIL midscan_reset: got dout=%h ch=%0d vld=%b wrap=%b, want all zero", dout_a, ch_a, vld_a, wrap_a);
    end
    rst_n = 1'b1; en = 1'b0;
    tick();
    checks++;
    if (vld_a !== 1'b0 || ch_a !== 2'd0) begin
      errors++;
      $display("FAIL midscan_idle: got vld=%b ch=%0d, want vld=0 ch=0", vld_a, ch_a);
    end
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = $urandom;
      tick();
      checks++;
      if (ch_a !== ((i < 3) ? 2'd0 : 2'd1) || vld_a !== 1'b1 || dout_a !== e_dout[0]) begin
        errors++;
        $display("FAIL midscan_restart %0d: got ch=%0d vld=%b dout=%h, want ch=%0d vld=1 dout=%h",
                 i, ch_a, vld_a, dout_a, (i < 3) ? 0 : 1, e_dout[0]);
      end
    end
  endtask

  task automatic test_random();
    mode = 1'b1;
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 40) != 0);
      en    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      sel   = 2'($urandom);
      din   = $urandom;
      tick();
      checks++;
      if ({dout_a, ch_a, vld_a, wrap_a} !== {e_dout[0], e_ch[0], e_vld[0], e_wrap[0]}) begin
        errors++;
        $display("FAIL rand_a cyc=%0d: got %h/%0d/%b/%b, want %h/%0d/%b/%b", i,
                 dout_a, ch_a, vld_a, wrap_a, e_dout[0], e_ch[0], e_vld[0], e_wrap[0]);
      end
      checks++;
      if ({dout_b, ch_b, vld_b, wrap_b} !== {e_dout[1], e_ch[1], e_vld[1], e_wrap[1]}) begin
        errors++;
        $display("FAIL rand_b cyc=%0d: got %h/%0d/%b/%b, want %h/%0d/%b/%b", i,
                 dout_b, ch_b, vld_b, wrap_b, e_dout[1], e_ch[1], e_vld[1], e_wrap[1]);
      end
    end
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      sn[u] = 0; e_dout[u] = 8'h00; e_ch[u] = 2'd0; e_vld[u] = 1'b0; e_wrap[u] = 1'b0;
    end
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel = 2'd0; din = 32'h0;
    test_reset();
    test_manual_sweep();
    test_out_of_range();
    test_scan_rotation();
    test_stall_mode_switch();
    test_reset_mid_scan();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
